// File: rtl/reg_file_wr_arbiter_if.sv
// Bundle of source request/data lines and register-file write-port signals
// shared between the datapath sources and the write-port arbiter.
interface reg_file_wr_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             hold;
    logic             req_acc;
    logic             req_ldm;
    logic             req_se;
    logic [WIDTH-1:0] data_acc;
    logic [WIDTH-1:0] data_ldm;
    logic [WIDTH-1:0] data_se;
    logic             gnt_acc;
    logic             gnt_ldm;
    logic             gnt_se;
    logic             rf_rw;
    logic             rf_lacc;
    logic             rf_ldm;
    logic             rf_lse;
    logic [WIDTH-1:0] rf_acc;
    logic [WIDTH-1:0] rf_load;
    logic [WIDTH-1:0] rf_se;
    logic             busy;
    logic [7:0]       wr_count;

    // Datapath side: raises requests, presents data, observes grants and the write port.
    modport master (
        output hold, req_acc, req_ldm, req_se, data_acc, data_ldm, data_se,
        input  gnt_acc, gnt_ldm, gnt_se, rf_rw, rf_lacc, rf_ldm, rf_lse,
        input  rf_acc, rf_load, rf_se, busy, wr_count
    );

    // Arbiter side.
    modport slave (
        input  hold, req_acc, req_ldm, req_se, data_acc, data_ldm, data_se,
        output gnt_acc, gnt_ldm, gnt_se, rf_rw, rf_lacc, rf_ldm, rf_lse,
        output rf_acc, rf_load, rf_se, busy, wr_count
    );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Write-port arbiter for the register file: picks one of three sources
// (acc=0, ldm=1, se=2), latches its data and drives a single write cycle.
module reg_file_wr_arbiter #(
    parameter int WIDTH = 16,
    parameter bit RR    = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    reg_file_wr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [2:0]       req;
    logic [1:0]       start;
    logic [1:0]       win;
    logic [WIDTH-1:0] win_data;

    // Modulo-3 addition for pointer arithmetic; operands are always in 0..2.
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // First requester found walking start, start+1, start+2 (mod 3).
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] s0);
        logic [1:0] i1, i2;
        i1 = mod3_add(s0, 2'd1);
        i2 = mod3_add(s0, 2'd2);
        if (r[s0]) begin
            return s0;
        end else if (r[i1]) begin
            return i1;
        end else begin
            return i2;
        end
    endfunction

    assign req   = {bus.req_se, bus.req_ldm, bus.req_acc};
    assign start = RR ? ptr_q : 2'd0;
    assign win   = pick(req, start);

    // Source data mux for the current winner.
    always_comb begin
        win_data = bus.data_acc;
        case (win)
            2'd1:    win_data = bus.data_ldm;
            2'd2:    win_data = bus.data_se;
            default: win_data = bus.data_acc;
        endcase
    end

    // Next-state logic: capture in IDLE when not stalled, retire in WRITE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = 3'b000;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.hold && (req != 3'b000)) begin
                    state_d = WRITE;
                    data_d  = win_data;
                    gnt_d   = 3'b001 << win;
                    if (RR) begin
                        ptr_d = mod3_add(win, 2'd1);
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                cnt_d   = cnt_q + 8'd1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, grant, data and counter registers; reset aborts any write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 3'b000;
            data_q  <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rf_rw    = (state_q == WRITE);
    assign bus.busy     = (state_q == WRITE);
    assign bus.rf_lacc  = gnt_q[0];
    assign bus.rf_ldm   = gnt_q[1];
    assign bus.rf_lse   = gnt_q[2];
    assign bus.gnt_acc  = gnt_q[0];
    assign bus.gnt_ldm  = gnt_q[1];
    assign bus.gnt_se   = gnt_q[2];
    assign bus.rf_acc   = data_q;
    assign bus.rf_load  = data_q;
    assign bus.rf_se    = data_q;
    assign bus.wr_count = cnt_q;

endmodule
